reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Tracks in-flight writes to the 16-bit register file (R0–R7, SP, IH, T) and stalls the decode stage when an instruction reads, or would over-commit, a register that has a pending write. It sits beside the register file in the decode stage:
- The issue port is driven by the decoder.
- The retire port is driven by write-back, in the same cycle the register-file write is presented.

Per-register pending counters make it safe for several writes to the same register to be in flight at once.

## Interface
- `CNT_W`, default 2: pending-counter width; maximum in-flight writes per register is 2^CNT_W−1.
- `CLK` in 1: clock, rising edge.
- `RSTn` in 1: asynchronous reset, active-low.
- `issue_valid` in 1: decoder presents an instruction this cycle.
- `issue_src1_en`, `issue_src2_en` in 1: the operand is read.
- `issue_src_spec` in 2: read-select, same encoding as the register file (00 general, 01 SP, 10 IH, 11 T).
- `issue_src1`, `issue_src2` in 3: general-register indices.
- `issue_dst_en` in 1: the instruction writes a register.
- `issue_dst_spec` in 2: write-select, same encoding as `issue_src_spec`.
- `issue_dst` in 3: destination index.
- `retire_valid` in 1: write-back performs a register write this cycle.
- `retire_spec` in 2: write-back write-select, same encoding as `issue_src_spec`.
- `retire_dst` in 3: write-back destination index.
- `flush` in 1: pipeline flush; clear all pending state.
- `stall` out 1: decoder must hold; the issue is not accepted.
- `busy` out 11: bit i is set when register id i has a nonzero count.
- `err` out 1: sticky error flag (see Configuration).

## Operation
- **Register id (4-bit):**
  - spec 00 → {0, idx}, giving ids 0–7.
  - spec 01 → 8 (SP), spec 10 → 9 (IH), spec 11 → 10 (T).
  - Ids 11–15 are never produced.
- **Source selection:** when `issue_src_spec` ≠ 00, only src1 is checked. src2 is ignored, matching the register-file read port.
- **Source hazard:** a source is enabled and its register's count is nonzero. Exception: the count is 1 and a same-cycle retire targets that id. The register file writes on the falling edge, so the decode-stage read already sees the value and no stall is needed.
- **Destination full:** `issue_dst_en` is set and the destination count equals 2^CNT_W−1, unless a same-cycle retire frees that id.
- **Stall:** `stall` = `issue_valid` & (source hazard | destination full) & ~`flush`.
- **Accept:** an issue is accepted when `issue_valid` & ~`stall` & ~`flush`. On accept with `issue_dst_en` set, the destination count increments.
- **Retire:** `retire_valid` decrements the count for its id.
- **Same id, same cycle:** an accepted increment and a retire on the same id leave the count unchanged.
- **flush:** all counters go to 0 on the next edge. Flush has priority over simultaneous issue and retire.
- **Retire on a zero count:** the count stays 0. This is an underflow.

## Timing
- `stall` is combinational from the current counters and this cycle's issue/retire inputs; there is no cycle of latency.
- Counters update on the rising edge of `CLK`. `busy` is registered-equivalent: it derives from the counters only, with no input path.
- A register issued in cycle N shows `busy` = 1 from cycle N+1 until the edge after its final retire.
- **Reset (`RSTn` low, any time, including mid-operation):**
  - All counters are 0, `busy` = 0, `err` = 0.
  - `stall` follows its equation, so it is 0 when counters are clear.
  - Release is synchronized by the system; the block has no state beyond the counters and `err`.

## Configuration
- `REG_SB_CHECK_EN` defined:
  - `err` sets on retire underflow, and on an increment attempted at saturation (impossible unless `stall` is ignored).
  - `err` clears only on reset.
- `REG_SB_CHECK_EN` undefined:
  - `err` is tied to 0 and the check logic is absent.
  - Underflow and saturation still saturate silently.

## Structure
- **Shared package:**
  - register-id constants `REG_ID_SP`=8, `REG_ID_IH`=9, `REG_ID_T`=10, `REG_ID_NUM`=11;
  - the spec-select encoding constants;
  - the id width of 4.
- **One sub-module, `reg_id_decode`:** (spec, idx) → 4-bit id. It is instantiated four times: src1, src2, dst, retire.
- Counter array and hazard logic stay in the top module.

## Test plan
- **Reset:** after reset, src1 = R3 issued with no prior writes → `stall` = 0, `busy` = 0.
- **Read-after-write:** issue dst R2 (cycle 0); in cycle 1 issue src1 = R2 → `stall` = 1 until retire R2. In the retire cycle `stall` = 0 (falling-edge bypass) and `busy`[2] clears on the next edge.
- **Saturation:** three issues to SP with CNT_W = 2 → count 3. A fourth dst-SP issue → `stall` = 1. The same issue with a simultaneous retire SP → accepted and the count stays 3.
- **Special registers:** src_spec = 01 with `issue_src2` = R5, while R5 is busy → `stall` = 0, because src2 is ignored.
- **Flush:** flush with R1 and T pending, plus a simultaneous dst-R4 issue → the next cycle has all `busy` = 0 and the R4 issue is not recorded.
- **Underflow:** retire R6 with count 0 → count stays 0; `err` = 1 with `REG_SB_CHECK_EN` defined, `err` = 0 without it; `err` holds until `RSTn` is asserted.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register-id width, special-register ids
// and the read/write-select encoding shared with the register file.
package reg_scoreboard_pkg;

  localparam int REG_ID_W   = 4;
  localparam int REG_ID_NUM = 11;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  localparam reg_id_t REG_ID_SP = 4'd8;
  localparam reg_id_t REG_ID_IH = 4'd9;
  localparam reg_id_t REG_ID_T  = 4'd10;

  typedef enum logic [1:0] {
    SPEC_GEN = 2'b00,
    SPEC_SP  = 2'b01,
    SPEC_IH  = 2'b10,
    SPEC_T   = 2'b11
  } spec_e;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_id_decode.sv
// Maps a register-file (select, index) pair to the flat 4-bit scoreboard id.
module reg_id_decode
  import reg_scoreboard_pkg::*;
(
  input  logic [1:0] spec_i,
  input  logic [2:0] idx_i,
  output reg_id_t    id_o
);

  // NOTE: every path assigns id_o, so this block can never infer a latch.
  always_comb begin
    unique case (spec_e'(spec_i))
      SPEC_GEN: id_o = {1'b0, idx_i};
      SPEC_SP:  id_o = REG_ID_SP;
      SPEC_IH:  id_o = REG_ID_IH;
      default:  id_o = REG_ID_T;
    endcase
  end

endmodule : reg_id_decode

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the decode stage; stalls reads of, and over-commits to, registers
// with in-flight writes. Define REG_SB_CHECK_EN to enable the sticky underflow/saturation err flag.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  issue_valid,
  input  logic                  issue_src1_en,
  input  logic                  issue_src2_en,
  input  logic [1:0]            issue_src_spec,
  input  logic [2:0]            issue_src1,
  input  logic [2:0]            issue_src2,
  input  logic                  issue_dst_en,
  input  logic [1:0]            issue_dst_spec,
  input  logic [2:0]            issue_dst,
  input  logic                  retire_valid,
  input  logic [1:0]            retire_spec,
  input  logic [2:0]            retire_dst,
  input  logic                  flush,
  output logic                  stall,
  output logic [REG_ID_NUM-1:0] busy,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  reg_id_t src1_id, src2_id, dst_id, ret_id;

  logic [CNT_W-1:0] cnt_q [REG_ID_NUM];
  logic [CNT_W-1:0] cnt_d [REG_ID_NUM];
  logic [CNT_W-1:0] src1_cnt, src2_cnt, dst_cnt;

  logic                  src2_chk, src1_haz, src2_haz, dst_full, accept;
  logic [REG_ID_NUM-1:0] inc_vec, dec_vec;

  reg_id_decode u_dec_src1 (.spec_i(issue_src_spec), .idx_i(issue_src1), .id_o(src1_id));
  reg_id_decode u_dec_src2 (.spec_i(issue_src_spec), .idx_i(issue_src2), .id_o(src2_id));
  reg_id_decode u_dec_dst  (.spec_i(issue_dst_spec), .idx_i(issue_dst),  .id_o(dst_id));
  reg_id_decode u_dec_ret  (.spec_i(retire_spec),    .idx_i(retire_dst), .id_o(ret_id));

  // Counter lookup by one-hot compare; ids 11-15 are never produced and read as zero.
  always_comb begin
    src1_cnt = '0;
    src2_cnt = '0;
    dst_cnt  = '0;
    for (int i = 0; i < REG_ID_NUM; i++) begin
      if (src1_id == reg_id_t'(i)) src1_cnt = cnt_q[i];
      if (src2_id == reg_id_t'(i)) src2_cnt = cnt_q[i];
      if (dst_id  == reg_id_t'(i)) dst_cnt  = cnt_q[i];
    end
  end

  // Special-register reads use only the first read port, so src2 is meaningless then.
  assign src2_chk = issue_src2_en && (issue_src_spec == SPEC_GEN);

  // A count of one being retired this cycle is already visible through the falling-edge write.
  assign src1_haz = issue_src1_en && (src1_cnt != '0) &&
                    !((src1_cnt == CNT_ONE) && retire_valid && (ret_id == src1_id));
  assign src2_haz = src2_chk && (src2_cnt != '0) &&
                    !((src2_cnt == CNT_ONE) && retire_valid && (ret_id == src2_id));
  assign dst_full = issue_dst_en && (dst_cnt == CNT_MAX) &&
                    !(retire_valid && (ret_id == dst_id));

  assign stall  = issue_valid && (src1_haz || src2_haz || dst_full) && !flush;
  assign accept = issue_valid && !stall && !flush;

  always_comb begin
    for (int i = 0; i < REG_ID_NUM; i++) begin
      inc_vec[i] = accept && issue_dst_en && (dst_id == reg_id_t'(i));
      dec_vec[i] = retire_valid && (ret_id == reg_id_t'(i));
      busy[i]    = (cnt_q[i] != '0);
      cnt_d[i]   = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // NOTE: the counter array is small and is the block's entire state, so every entry is reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < REG_ID_NUM; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef REG_SB_CHECK_EN
  logic [REG_ID_NUM-1:0] full_vec;
  logic                  err_q, err_d;

  always_comb begin
    for (int i = 0; i < REG_ID_NUM; i++) full_vec[i] = (cnt_q[i] == CNT_MAX);
    err_d = err_q ||
            (!flush && (|(dec_vec & ~inc_vec & ~busy) || |(inc_vec & ~dec_vec & full_vec)));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver queues the expected stall/busy/err for each
// cycle and an independent negedge monitor pops and compares them.
module tb_reg_scoreboard;

  localparam logic [1:0] G = 2'b00, SP = 2'b01, T = 2'b11;

`ifdef REG_SB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        issue_valid, issue_src1_en, issue_src2_en, issue_dst_en;
  logic [1:0]  issue_src_spec, issue_dst_spec, retire_spec;
  logic [2:0]  issue_src1, issue_src2, issue_dst, retire_dst;
  logic        retire_valid, flush;
  logic        stall, err;
  logic [10:0] busy;

  typedef struct {
    string       name;
    logic        stall;
    logic [10:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  reg_scoreboard #(.CNT_W(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .issue_valid(issue_valid), .issue_src1_en(issue_src1_en), .issue_src2_en(issue_src2_en),
    .issue_src_spec(issue_src_spec), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_dst_en(issue_dst_en), .issue_dst_spec(issue_dst_spec), .issue_dst(issue_dst),
    .retire_valid(retire_valid), .retire_spec(retire_spec), .retire_dst(retire_dst),
    .flush(flush), .stall(stall), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".stall"}, {10'b0, stall}, {10'b0, e.stall});
      check({e.name, ".busy"},  busy,           e.busy);
      check({e.name, ".err"},   {10'b0, err},   {10'b0, e.err});
    end
  end

  task automatic clr();
    issue_valid = 0; issue_src1_en = 0; issue_src2_en = 0; issue_dst_en = 0;
    issue_src_spec = G; issue_dst_spec = G; retire_spec = G;
    issue_src1 = 0; issue_src2 = 0; issue_dst = 0; retire_dst = 0;
    retire_valid = 0; flush = 0;
  endtask

  task automatic rd1(input logic [1:0] s, input logic [2:0] r);
    issue_valid = 1; issue_src1_en = 1; issue_src_spec = s; issue_src1 = r;
  endtask

  task automatic wr(input logic [1:0] s, input logic [2:0] r);
    issue_valid = 1; issue_dst_en = 1; issue_dst_spec = s; issue_dst = r;
  endtask

  task automatic ret(input logic [1:0] s, input logic [2:0] r);
    retire_valid = 1; retire_spec = s; retire_dst = r;
  endtask

  // Queue this cycle's expectation, let the edge happen, then clear inputs for the next cycle.
  task automatic step(input string name, input logic s, input logic [10:0] b, input logic e);
    exp_t x;
    x.name = name; x.stall = s; x.busy = b; x.err = e;
    exp_q.push_back(x);
    @(posedge CLK);
    #1;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    RSTn = 0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1;

    rd1(G, 3);                       step("reset_src_r3",   0, 11'h000, 0);

    wr(G, 2);                        step("raw_issue_r2",   0, 11'h000, 0);
    rd1(G, 2);                       step("raw_read_r2_a",  1, 11'h004, 0);
    rd1(G, 2);                       step("raw_read_r2_b",  1, 11'h004, 0);
    rd1(G, 2); ret(G, 2);            step("raw_bypass",     0, 11'h004, 0);
                                     step("raw_busy_clr",   0, 11'h000, 0);

    for (int i = 0; i < 3; i++) begin
      wr(SP, 0);                     step($sformatf("sat_fill%0d", i), 0, (i == 0) ? 11'h000 : 11'h100, 0);
    end
    wr(SP, 0);                       step("sat_full",       1, 11'h100, 0);
    wr(SP, 0); ret(SP, 0);           step("sat_ret_accept", 0, 11'h100, 0);
    wr(SP, 0);                       step("sat_still_full", 1, 11'h100, 0);
    rd1(SP, 0); ret(SP, 0);          step("drain_cnt3",     1, 11'h100, 0);
    rd1(SP, 0); ret(SP, 0);          step("drain_cnt2",     1, 11'h100, 0);
    rd1(SP, 0); ret(SP, 0);          step("drain_cnt1",     0, 11'h100, 0);
                                     step("drain_done",     0, 11'h000, 0);

    wr(G, 5);                        step("spec_issue_r5",  0, 11'h000, 0);
    rd1(SP, 0); issue_src2_en = 1; issue_src2 = 5;
                                     step("spec_src2_ign",  0, 11'h020, 0);
    rd1(G, 0); issue_src2_en = 1; issue_src2 = 5;
                                     step("gen_src2_haz",   1, 11'h020, 0);
    ret(G, 5);                       step("r5_retire",      0, 11'h020, 0);

    wr(G, 1);                        step("flush_wr_r1",    0, 11'h000, 0);
    wr(T, 0);                        step("flush_wr_t",     0, 11'h002, 0);
    wr(G, 4); issue_src1_en = 1; issue_src1 = 1; flush = 1;
                                     step("flush_cycle",    0, 11'h402, 0);
                                     step("flush_after",    0, 11'h000, 0);

    ret(G, 6);                       step("udf_retire_r6",  0, 11'h000, 0);
                                     step("udf_err_set",    0, 11'h000, EXP_ERR);
                                     step("udf_err_hold",   0, 11'h000, EXP_ERR);
    wr(G, 6);                        step("udf_cnt_zero",   0, 11'h000, EXP_ERR);
    rd1(G, 6);                       step("r6_pending",     1, 11'h040, EXP_ERR);

    RSTn = 0;
    rd1(G, 6);                       step("midop_reset",    0, 11'h000, 0);
    RSTn = 1;
                                     step("post_reset",     0, 11'h000, 0);

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL monitor_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_scoreboard
